// File: rtl/cmp_pipe.sv
// Two-stage pipelined relational compare / MIN-MAX unit with
// valid/ready handshakes and saturating outcome statistics.
module cmp_pipe #(
    parameter int WIDTH     = 8,
    parameter int RES_WIDTH = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [2:0]           in_op,
    input  logic                 in_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [RES_WIDTH-1:0] out_result,
    output logic [2:0]           out_flags,
    input  logic                 clr_stats,
    output logic [CNT_WIDTH-1:0] total_count,
    output logic [CNT_WIDTH-1:0] true_count
);

    localparam logic [2:0] OP_EQ  = 3'd0;
    localparam logic [2:0] OP_NE  = 3'd1;
    localparam logic [2:0] OP_LT  = 3'd2;
    localparam logic [2:0] OP_LE  = 3'd3;
    localparam logic [2:0] OP_GT  = 3'd4;
    localparam logic [2:0] OP_GE  = 3'd5;
    localparam logic [2:0] OP_MIN = 3'd6;

    logic                 s1_valid;
    logic [WIDTH-1:0]     s1_a;
    logic [WIDTH-1:0]     s1_b;
    logic [2:0]           s1_op;
    logic                 s1_signed;
    logic                 s2_true;
    logic                 s2_adv;

    logic                 eq;
    logic                 lt;
    logic                 gt;
    logic                 sel_a;
    logic                 pred;
    logic                 is_sel;
    logic [RES_WIDTH-1:0] res;

    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_op     <= '0;
            s1_signed <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a      <= in_a;
                s1_b      <= in_b;
                s1_op     <= in_op;
                s1_signed <= in_signed;
            end
        end
    end

    // Signed mode flips both sign bits so one unsigned compare serves both.
    always_comb begin
        eq = (s1_a == s1_b);
        lt = ({s1_a[WIDTH-1] ^ s1_signed, s1_a[WIDTH-2:0]}
            < {s1_b[WIDTH-1] ^ s1_signed, s1_b[WIDTH-2:0]});
        gt = !lt && !eq;
    end

    always_comb begin
        pred   = 1'b0;
        sel_a  = 1'b0;
        is_sel = 1'b0;
        res    = '0;
        case (s1_op)
            OP_EQ:   pred = eq;
            OP_NE:   pred = !eq;
            OP_LT:   pred = lt;
            OP_LE:   pred = lt || eq;
            OP_GT:   pred = gt;
            OP_GE:   pred = gt || eq;
            OP_MIN: begin
                is_sel = 1'b1;
                sel_a  = lt || eq;
            end
            default: begin
                is_sel = 1'b1;
                sel_a  = gt || eq;
            end
        endcase
        if (is_sel) begin
            res[WIDTH-1:0] = sel_a ? s1_a : s1_b;
        end else begin
            res[0] = pred;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
            s2_true    <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_result <= res;
                out_flags  <= {gt, lt, eq};
                s2_true    <= is_sel ? sel_a : pred;
            end
        end
    end

    // Clear has priority over a same-cycle handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_count <= '0;
            true_count  <= '0;
        end else if (clr_stats) begin
            total_count <= '0;
            true_count  <= '0;
        end else if (out_valid && out_ready) begin
            if (total_count != '1) begin
                total_count <= total_count + 1'b1;
            end
            if (s2_true && (true_count != '1)) begin
                true_count <= true_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cmp_pipe.sv
// Directed self-checking bench for cmp_pipe (8-bit operands,
// 2-bit counters so saturation is reachable).
module tb_cmp_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [2:0] in_op;
    logic       in_signed;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic [2:0] out_flags;
    logic       clr_stats;
    logic [1:0] total_count;
    logic [1:0] true_count;

    int checks = 0;
    int errors = 0;

    cmp_pipe #(.WIDTH(8), .RES_WIDTH(8), .CNT_WIDTH(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_a(in_a),
        .in_b(in_b),
        .in_op(in_op),
        .in_signed(in_signed),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_result(out_result),
        .out_flags(out_flags),
        .clr_stats(clr_stats),
        .total_count(total_count),
        .true_count(true_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One unstalled transaction: accept, check bubble, check result.
    task automatic xact(input string tag, input logic [7:0] a,
                        input logic [7:0] b, input logic [2:0] op,
                        input logic sgn, input logic [7:0] exp_res,
                        input logic [2:0] exp_flags);
        @(negedge clk);
        in_a      = a;
        in_b      = b;
        in_op     = op;
        in_signed = sgn;
        in_valid  = 1'b1;
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
        chk({tag, "_res"}, 32'(out_result), 32'(exp_res));
        chk({tag, "_flg"}, 32'(out_flags), 32'(exp_flags));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = '0;
        in_signed = 1'b0;
        out_ready = 1'b1;
        clr_stats = 1'b0;

        repeat (3) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_a      = 8'($urandom);
            in_b      = 8'($urandom);
            in_op     = 3'($urandom);
            in_signed = 1'($urandom);
        end
        @(negedge clk);
        chk("rst_vld", 32'(out_valid), 32'd0);
        chk("rst_res", 32'(out_result), 32'd0);
        chk("rst_flg", 32'(out_flags), 32'd0);
        chk("rst_tot", 32'(total_count), 32'd0);
        chk("rst_tru", 32'(true_count), 32'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        #1;
        chk("rst_rdy", 32'(in_ready), 32'd1);

        xact("gt_u",   8'd1,    8'd0,    3'd4, 1'b0, 8'h01, 3'b100);
        xact("lt_u",   8'd2,    8'd8,    3'd2, 1'b0, 8'h01, 3'b010);
        xact("eq_u",   8'd2,    8'd8,    3'd0, 1'b0, 8'h00, 3'b010);
        xact("lt_s",   8'hFF,   8'h01,   3'd2, 1'b1, 8'h01, 3'b010);
        xact("lt_u2",  8'hFF,   8'h01,   3'd2, 1'b0, 8'h00, 3'b100);
        xact("min_s",  8'h80,   8'h7F,   3'd6, 1'b1, 8'h80, 3'b010);
        xact("ge_tie", 8'h05,   8'h05,   3'd5, 1'b0, 8'h01, 3'b001);
        xact("max_s",  8'h80,   8'h7F,   3'd7, 1'b1, 8'h7F, 3'b010);
        // Seven handshakes so far, five of them true: both saturate.
        chk("sat_tot", 32'(total_count), 32'd3);
        chk("sat_tru", 32'(true_count), 32'd3);

        // Clear in the same cycle as the max_s handshake.
        @(negedge clk);
        clr_stats = 1'b1;
        chk("clr_hs", 32'(out_valid && out_ready), 32'd1);
        @(posedge clk);
        #1;
        clr_stats = 1'b0;
        chk("clr_tot", 32'(total_count), 32'd0);
        chk("clr_tru", 32'(true_count), 32'd0);
        chk("clr_vld", 32'(out_valid), 32'd0);

        xact("max_tie", 8'h33, 8'h33, 3'd7, 1'b1, 8'h33, 3'b001);
        @(posedge clk);
        #1;
        chk("tie_tot", 32'(total_count), 32'd1);
        chk("tie_tru", 32'(true_count), 32'd1);

        @(negedge clk);
        clr_stats = 1'b1;
        @(negedge clk);
        clr_stats = 1'b0;

        // Back-pressure: three requests, only two fit.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a = 8'd10; in_b = 8'd20; in_op = 3'd7; in_signed = 1'b0;
        #1;
        chk("bp_rdy0", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_op = 3'd6;
        #1;
        chk("bp_rdy1", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_a = 8'd3; in_b = 8'd4; in_op = 3'd1;
        #1;
        chk("bp_rdy2", 32'(in_ready), 32'd0);
        chk("bp_vld", 32'(out_valid), 32'd1);
        chk("bp_hold0", 32'(out_result), 32'h14);
        @(negedge clk);
        chk("bp_hold1", 32'(out_result), 32'h14);
        chk("bp_rdy3", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        #1;
        chk("bp_rdy4", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_r1v", 32'(out_valid), 32'd1);
        chk("bp_r1", 32'(out_result), 32'h0A);
        @(posedge clk);
        #1;
        chk("bp_r2v", 32'(out_valid), 32'd1);
        chk("bp_r2", 32'(out_result), 32'h01);
        chk("bp_r2f", 32'(out_flags), 32'b010);
        @(posedge clk);
        #1;
        chk("bp_end", 32'(out_valid), 32'd0);
        chk("bp_tot", 32'(total_count), 32'd3);
        chk("bp_tru", 32'(true_count), 32'd2);

        // Asynchronous reset mid-flight drops the in-flight request.
        @(negedge clk);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("ar_tot", 32'(total_count), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ar_vld", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/cmp_pipe.md
# cmp_pipe

Parametrised, pipelined comparison unit for the Tiny-CPU datapath. It takes two WIDTH-bit operands, an operation code and a signedness bit. Each operation is one of six relational predicates or a MIN/MAX select. It returns a registered result word and relation flags after a fixed two-stage latency, using valid/ready handshakes on both sides. It also keeps saturating statistics counters, which the control unit reads for branch profiling.

## Interface
Parameters:
- WIDTH, 8, operand width in bits (≥2).
- RES_WIDTH, 8, result word width; must be ≥ WIDTH.
- CNT_WIDTH, 16, width of each statistics counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  upstream request.
- in_ready  output  1  block accepts the request this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_op  input  3  operation: 0 EQ, 1 NE, 2 LT, 3 LE, 4 GT, 5 GE, 6 MIN, 7 MAX.
- in_signed  input  1  1 = two's-complement compare, 0 = unsigned.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out_result  output  RES_WIDTH  predicate ops: bit 0 = predicate, upper bits 0. MIN/MAX: selected operand, zero-extended.
- out_flags  output  3  {gt, lt, eq} of A vs B under the selected signedness.
- clr_stats  input  1  synchronous clear of both counters.
- total_count  output  CNT_WIDTH  number of output handshakes.
- true_count  output  CNT_WIDTH  number of output handshakes with a "true" outcome.

## Operation
- Input handshake: a transfer occurs when in_valid && in_ready. An output handshake occurs when out_valid && out_ready.
- Stage 1 (S1) registers in_a, in_b, in_op and in_signed, and sets s1_valid.
- Stage 2 (S2) computes the comparison from the S1 registers and registers out_result, out_flags, out_valid and a true bit.
- Advance rules:
  - s2_adv = !out_valid || out_ready.
  - s1_adv = s2_adv.
  - in_ready = !s1_valid || s1_adv.
  - The ready path is combinational from out_ready.
- When S1 advances with s1_valid = 0, S2 loads out_valid = 0. When no stage advances, all registers hold.
- Comparison rules:
  - Signed mode: compare with the MSB as sign bit.
  - Unsigned mode: plain magnitude compare.
  - Exactly one of gt, lt, eq is 1 for every result.
- LE = lt|eq and GE = gt|eq. NE = !eq.
- MIN selects A when A ≤ B, else B. MAX selects A when A ≥ B, else B. On a tie, A is selected.
- True bit:
  - Predicate ops: the predicate value.
  - MIN/MAX: 1 when A was selected.
- Statistics:
  - On an output handshake, total_count increments by 1, and true_count increments by 1 if the true bit is set.
  - Both counters saturate at all-ones; they do not wrap.
  - clr_stats zeroes both counters. When clr_stats and a handshake occur in the same cycle, clear wins and the handshake is not counted.
  - clr_stats does not affect pipeline contents.
- No transaction is ever dropped or duplicated, and results leave in acceptance order.

## Timing
- Reset (rst_n low, asynchronous) sets: in_ready = 1 after release, out_valid = 0, out_result = 0, out_flags = 0, total_count = 0, true_count = 0. s1_valid is cleared.
- Asserting reset mid-operation discards all in-flight transactions immediately.
- Latency: request accepted at edge N → out_valid = 1 after edge N+1, provided the pipeline is not stalled.
- Throughput: one transaction per cycle while out_ready stays high.
- Back-pressure: if out_ready is low while out_valid is high, S2 holds. S1 then fills, and in_ready drops in the same cycle S1 holds valid data. At most 2 transactions are buffered.
- Simultaneous events: if out_ready returns high while in_valid is high, the block drains S2, shifts S1 to S2 and accepts the new request in one edge.
- out_result, out_flags and out_valid are stable while out_valid && !out_ready.
- Counters update on the same edge as the output handshake.

## Test plan
- Reset check: hold rst_n low with random inputs → out_valid = 0, out_result = 0x00, out_flags = 0, both counters 0. After release, in_ready = 1.
- Unsigned compare:
  - GT a=1, b=0 → out_result 0x01, flags 3'b100, valid after 2 edges.
  - LT a=2, b=8 → 0x01, flags 3'b010.
  - EQ a=2, b=8 → 0x00.
- Signed compare, LT with a=0xFF, b=0x01: signed → 0x01, flags 3'b010. Unsigned → 0x00, flags 3'b100.
- MIN/MAX, signed:
  - MIN a=0x80, b=0x7F → 0x80, true bit set.
  - MAX with the same operands → 0x7F.
  - MAX tie a=b=0x33 → 0x33, true_count increments.
- Back-pressure: hold out_ready = 0 and offer three back-to-back requests → only two are accepted and in_ready goes low. Raise out_ready → results emerge in order with none lost, and total_count = 3 after draining.
- Counter edges, with CNT_WIDTH=2:
  - Five true handshakes → true_count = 3 (saturated).
  - Assert clr_stats in a handshake cycle → both counters read 0 on the next cycle.
